// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a byte stream with a 16-bit word-count header,
// packs little-endian 32-bit words into imem and holds the core in reset until the image is in.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_HDR_LO = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]        r_state,    w_state_nxt;
  logic [15:0]       r_count,    w_count_nxt;
  logic [16:0]       r_word_cnt, w_word_cnt_nxt;
  logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic [23:0]       r_shift,    w_shift_nxt;
  logic              r_wr_en,    w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr,  w_wr_addr_nxt;
  logic [31:0]       r_wr_data,  w_wr_data_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_error,    w_error_nxt;

  logic        w_accept;
  logic [15:0] w_hdr;
  logic [31:0] w_hdr_ext;
  logic [16:0] w_word_cnt_inc;

  assign in_ready       = (r_state == S_HDR_LO) || (r_state == S_HDR_HI) || (r_state == S_DATA);
  assign w_accept       = in_valid && in_ready;
  assign w_hdr          = {in_data, r_count[7:0]};
  assign w_hdr_ext      = {16'd0, w_hdr};
  assign w_word_cnt_inc = r_word_cnt + 17'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_word_cnt_nxt = r_word_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_cpu_hold_nxt = r_cpu_hold;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;

    case (r_state)
      S_HDR_LO: begin
        if (w_accept) begin
          w_count_nxt[7:0] = in_data;
          w_state_nxt      = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (w_accept) begin
          w_count_nxt = w_hdr;
          if (w_hdr_ext > DEPTH) begin
            w_state_nxt = S_ERR;
            w_error_nxt = 1'b1;
          end else if (w_hdr == 16'd0) begin
            w_state_nxt    = S_DONE;
            w_done_nxt     = 1'b1;
            w_cpu_hold_nxt = 1'b0;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          if (r_byte_cnt == 2'd3) begin
            w_wr_en_nxt    = 1'b1;
            w_wr_addr_nxt  = r_word_cnt[ADDR_W-1:0];
            w_wr_data_nxt  = {in_data, r_shift};
            w_word_cnt_nxt = w_word_cnt_inc;
            w_byte_cnt_nxt = 2'd0;
            if (w_word_cnt_inc == {1'b0, r_count}) begin
              w_state_nxt = S_FLUSH;
            end
          end else begin
            w_shift_nxt[{r_byte_cnt, 3'b000} +: 8] = in_data;
            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          end
        end
      end
      S_FLUSH: begin
        // Final strobe is visible this cycle; the core is released one cycle after it.
        w_state_nxt    = S_DONE;
        w_done_nxt     = 1'b1;
        w_cpu_hold_nxt = 1'b0;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          w_state_nxt    = S_HDR_LO;
          w_done_nxt     = 1'b0;
          w_error_nxt    = 1'b0;
          w_word_cnt_nxt = 17'd0;
          w_byte_cnt_nxt = 2'd0;
          w_cpu_hold_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_HDR_LO;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_HDR_LO;
      r_count    <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_cpu_hold <= w_cpu_hold_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams small images and checks strobes, hold and status.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        start;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  img[$];

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .start    (start),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  // Record every write strobe shortly after the edge that produced it.
  always @(posedge clock) begin
    #2;
    if (wr_en === 1'b1) begin
      log_addr.push_back({26'd0, wr_addr});
      log_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] addr,
                             input logic [31:0] data);
    if (log_addr.size() > idx) begin
      check({tag, "_addr"}, log_addr[idx], addr);
      check({tag, "_data"}, log_data[idx], data);
    end else begin
      check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      @(negedge clock);
    end
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic send_img(input bit gap);
    foreach (img[i]) send_byte(img[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   {31'd0, in_ready}, 32'd1);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"},  {31'd0, done},     32'd0);
    check({tag, "_err"},   {31'd0, error},    32'd0);
    check({tag, "_wren"},  {31'd0, wr_en},    32'd0);
    check({tag, "_waddr"}, {26'd0, wr_addr},  32'd0);
    check({tag, "_wdata"}, wr_data,           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    idle(2);
    check_reset_outputs("rst");
    reset = 1'b1;
    idle(1);

    // Two-word image, in_valid held high.
    clear_log();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    send_img(1'b0);
    check("t1_flush_wren",  {31'd0, wr_en},    32'd1);
    check("t1_flush_addr",  {26'd0, wr_addr},  32'd1);
    check("t1_flush_data",  wr_data,           32'h00A00093);
    check("t1_flush_rdy",   {31'd0, in_ready}, 32'd0);
    check("t1_flush_done",  {31'd0, done},     32'd0);
    check("t1_flush_hold",  {31'd0, cpu_hold}, 32'd1);
    idle(1);
    check("t1_done",        {31'd0, done},     32'd1);
    check("t1_hold",        {31'd0, cpu_hold}, 32'd0);
    check("t1_wren_off",    {31'd0, wr_en},    32'd0);
    idle(3);
    in_valid = 1'b0;
    check("t1_nwrites", 32'(log_addr.size()), 32'd2);
    check_write("t1_w0", 0, 32'd0, 32'h00500013);
    check_write("t1_w1", 1, 32'd1, 32'h00A00093);

    // Same image with in_valid toggling, then in_valid held in DONE.
    pulse_start();
    check("t2_hold_rearm", {31'd0, cpu_hold}, 32'd1);
    check("t2_done_clr",   {31'd0, done},     32'd0);
    check("t2_rdy_rearm",  {31'd0, in_ready}, 32'd1);
    clear_log();
    send_img(1'b1);
    idle(2);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    idle(4);
    check("t2_rdy_done",  {31'd0, in_ready}, 32'd0);
    check("t2_done",      {31'd0, done},     32'd1);
    check("t2_hold",      {31'd0, cpu_hold}, 32'd0);
    check("t2_nwrites",   32'(log_addr.size()), 32'd2);
    check_write("t2_w0", 0, 32'd0, 32'h00500013);
    check_write("t2_w1", 1, 32'd1, 32'h00A00093);
    in_valid = 1'b0;

    // Oversized header N=65.
    pulse_start();
    clear_log();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    check("t3_err",  {31'd0, error},    32'd1);
    check("t3_hold", {31'd0, cpu_hold}, 32'd1);
    check("t3_rdy",  {31'd0, in_ready}, 32'd0);
    check("t3_done", {31'd0, done},     32'd0);
    idle(3);
    check("t3_nwrites", 32'(log_addr.size()), 32'd0);
    pulse_start();
    check("t3_err_clr", {31'd0, error},    32'd0);
    check("t3_rdy_arm", {31'd0, in_ready}, 32'd1);

    // Empty image: release on the header edge.
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    check("t4_done", {31'd0, done},     32'd1);
    check("t4_hold", {31'd0, cpu_hold}, 32'd0);
    idle(3);
    check("t4_nwrites", 32'(log_addr.size()), 32'd0);

    // N=64 is the largest legal size.
    pulse_start();
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    check("t4b_err", {31'd0, error},    32'd0);
    check("t4b_rdy", {31'd0, in_ready}, 32'd1);

    // Reset mid-load, then a fresh image.
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(1);
    clear_log();
    img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_img(1'b0);
    in_valid = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(1);
    check_reset_outputs("t5_rst");
    reset = 1'b1;
    check("t5_nwrites", 32'(log_addr.size()), 32'd1);
    check_write("t5_w0", 0, 32'd0, 32'h44332211);
    idle(1);
    clear_log();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    send_img(1'b0);
    in_valid = 1'b0;
    idle(3);
    check("t5_done",    {31'd0, done}, 32'd1);
    check("t5_nwrites2", 32'(log_addr.size()), 32'd2);
    check_write("t5_f0", 0, 32'd0, 32'h00500013);
    check_write("t5_f1", 1, 32'd1, 32'h00A00093);

    // Reload a single word after DONE.
    pulse_start();
    clear_log();
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_img(1'b0);
    in_valid = 1'b0;
    check("t6_wren", {31'd0, wr_en},    32'd1);
    check("t6_hold", {31'd0, cpu_hold}, 32'd1);
    idle(1);
    check("t6_done",    {31'd0, done},     32'd1);
    check("t6_release", {31'd0, cpu_hold}, 32'd0);
    idle(2);
    check("t6_nwrites", 32'(log_addr.size()), 32'd1);
    check_write("t6_w0", 0, 32'd0, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the core in reset until the whole image is written, then releases it so the core fetches from PC 0.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory; maximum accepted image size.
- ADDR_W, 6, width of the word-index write address; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- start  in  1  single-cycle pulse that re-arms the loader from DONE or ERR.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word index being written.
- wr_data  out  32  assembled word.
- cpu_hold  out  1  active-high reset hold to the core.
- done  out  1  image fully loaded.
- error  out  1  header word count exceeded DEPTH.

Behaviour:
- States: HDR_LO, HDR_HI, DATA, FLUSH, DONE, ERR.
- Reset values (asynchronous, while reset=0): state=HDR_LO, cpu_hold=1, done=0, error=0, wr_en=0, wr_addr=0, wr_data=0, byte_cnt=0, word_cnt=0, count=0.
- in_ready is combinational: 1 in HDR_LO, HDR_HI and DATA; 0 in FLUSH, DONE and ERR.
- A byte is accepted only on a rising edge with in_valid=1 and in_ready=1. in_valid without in_ready is ignored, and no byte is lost or duplicated.
- HDR_LO: accept byte, load count[7:0], go to HDR_HI.
- HDR_HI: accept byte, load count[15:8], then branch on the completed 16-bit count N:
  - N > DEPTH: go to ERR; error=1 on the same edge.
  - N == 0: go to DONE; done=1 and cpu_hold=0 on the same edge.
  - otherwise: go to DATA.
- DATA: each accepted byte goes into the shift register at lane byte_cnt (byte 0 -> bits 7:0), and byte_cnt (2-bit) increments.
- On the edge accepting the 4th byte (byte_cnt==3):
  - register wr_en=1, wr_addr=word_cnt[ADDR_W-1:0], wr_data={b3,b2,b1,b0};
  - word_cnt increments and byte_cnt wraps to 0.
  - If word_cnt+1 == N, go to FLUSH; otherwise stay in DATA.
- wr_en is high for exactly one cycle per word and is 0 on every other cycle. wr_addr and wr_data hold their last values when wr_en=0.
- FLUSH: lasts one cycle, with wr_en high for the final word. Next edge goes to DONE; done=1 and cpu_hold=0 on that edge, so the core leaves reset one cycle after the last write strobe.
- DONE: outputs hold. start=1 clears done, error, word_cnt and byte_cnt, sets cpu_hold=1, and goes to HDR_LO.
- ERR: cpu_hold=1 and error=1 hold. start=1 re-arms exactly as from DONE.
- start is ignored in HDR_LO, HDR_HI, DATA and FLUSH.
- Reset mid-load: everything returns to reset values immediately. Words already written stay in memory and are not erased. A partial word (byte_cnt != 0) is discarded.
- Width rules:
  - count is 16 bits and word_cnt is 17 bits, so no wrap before the compare.
  - The N > DEPTH compare is unsigned at full width.

Test Plan:
- Reset, then stream 02 00 | 13 00 50 00 | 93 00 A0 00 with in_valid held high -> wr_en pulses twice: addr 0 data 0x00500013, then addr 1 data 0x00A00093. One cycle after the second pulse, done=1 and cpu_hold=0. No further writes.
- Same image with in_valid toggling 1/0 every cycle, plus in_valid=1 while in DONE -> identical writes; in_ready=0 in DONE and no extra wr_en.
- Header 41 00 (N=65 > DEPTH=64) -> error=1, cpu_hold=1, in_ready=0, no wr_en. Then pulse start -> error=0 and the loader accepts a new header.
- Header 00 00 -> done=1 and cpu_hold=0 on the HDR_HI accept edge; no wr_en ever.
- Header N=3; after 5 data bytes, assert reset low for 1 cycle -> all outputs at reset values, one write (addr 0) has occurred. A full fresh image afterwards loads correctly from addr 0.
- After DONE, pulse start and load N=1 word 0xDEADBEEF -> cpu_hold=1 during reload; single write addr 0 data 0xDEADBEEF; then done=1 and cpu_hold=0.
